// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: on-chip instruction memory, sequential prefetch into a small FIFO.
// Optional misaligned-redirect fault (sticky, blocks issue) when IFETCH_ALIGN_CHK_EN is defined.
module instr_fetch_unit #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data
`ifdef IFETCH_ALIGN_CHK_EN
  ,
  output logic                  fault
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [31:0]           fifo_pc [FIFO_DEPTH];

  logic [31:0]           fetch_pc;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [31:0]           rd_pc;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  blocked;
  logic [31:0]           redirect_tgt;
  logic [CW:0]           used;

`ifdef IFETCH_ALIGN_CHK_EN
  assign blocked      = fault;
  assign redirect_tgt = redirect_pc;
`else
  assign blocked      = 1'b0;
  assign redirect_tgt = redirect_pc & ~32'h3;
`endif

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;

  assign push = rd_vld;
  assign pop  = instr_valid & instr_ready;

  // Credit: buffered entries plus the word in flight, minus what leaves this cycle.
  assign used  = {1'b0, count} + (CW+1)'(rd_vld) - (CW+1)'(pop);
  assign issue = ena & ~redirect_valid & ~blocked & (used < (CW+1)'(FIFO_DEPTH));

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (prog_we)
      mem[prog_addr] <= prog_data;
    if (issue)
      rd_data <= mem[fetch_pc[ADDR_WIDTH+1:2]];
    if (push && !redirect_valid) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_pc[wr_ptr]   <= rd_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rd_vld   <= 1'b0;
      rd_pc    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
`ifdef IFETCH_ALIGN_CHK_EN
      fault    <= 1'b0;
`endif
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
      rd_vld   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
`ifdef IFETCH_ALIGN_CHK_EN
      fault    <= (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      rd_vld <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        rd_pc    <= fetch_pc;
      end
      if (push)
        wr_ptr <= ptr_next(wr_ptr);
      if (pop)
        rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard predicts the delivered stream
// from the program image and redirect/reset history; directed cases plus random traffic.
module tb_instr_fetch_unit;

  localparam int          DW  = 32;
  localparam int          AW  = 10;
  localparam int          FD  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [31:0]   instr_pc;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
`ifdef IFETCH_ALIGN_CHK_EN
  logic          fault;
`endif

  instr_fetch_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
`ifdef IFETCH_ALIGN_CHK_EN
    , .fault(fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model_mem [2**AW];
  logic [31:0]   exp_pc;
  int            n_deliv = 0;
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_i;
  logic [31:0]   hold_p;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream scoreboard: each delivered word must be the next sequential word since the
  // last reset/redirect; a stalled head must not change.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = RPC;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", instr_valid, 1'b1);
        check("hold_instr", instr, hold_i);
        check("hold_pc", instr_pc, hold_p);
      end
      if (instr_valid && instr_ready) begin
        check("deliv_pc", instr_pc, exp_pc);
        check("deliv_instr", instr, model_mem[exp_pc[AW+1:2]]);
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      hold_v = instr_valid && !instr_ready && !redirect_valid;
      hold_i = instr;
      hold_p = instr_pc;
      if (redirect_valid)
        exp_pc = redirect_pc & ~32'h3;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !instr_valid; i++)
      step();
    check(tag, instr_valid, 1'b1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int d0;
    int vcnt;
    rst_n = 1'b0; ena = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    #2;
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, '0);
    check("rst_pc", instr_pc, '0);
`ifdef IFETCH_ALIGN_CHK_EN
    check("rst_fault", fault, 1'b0);
`endif
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Load program with fetch disabled.
    for (int i = 0; i < 2**AW; i++)
      model_mem[i] = (i < 8) ? (32'h100 + 32'(i)) : $urandom;
    for (int i = 0; i < 2**AW; i++) begin
      step();
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = model_mem[i];
    end
    step();
    prog_we = 1'b0;
    check("idle_no_fetch", instr_valid, 1'b0);

    // Reset with fetch enabled: valid after the second edge, sequential stream.
    @(posedge clk); #3 rst_n = 1'b0;
    ena = 1'b1; instr_ready = 1'b1;
    step(); step();
    #2 rst_n = 1'b1;
    step();
    check("edge1_valid", instr_valid, 1'b0);
    step();
    check("edge2_valid", instr_valid, 1'b1);
    check("edge2_pc", instr_pc, RPC);
    check("edge2_instr", instr, 32'h100);
    vcnt = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (instr_valid) vcnt++;
    end
    check("seq_throughput", vcnt, 7);

    // Backpressure: head frozen, then exactly FD entries drain.
    instr_ready = 1'b0;
    repeat (10) step();
    check("bp_valid", instr_valid, 1'b1);
    check("bp_head_pc", instr_pc, exp_pc);
    ena = 1'b0; instr_ready = 1'b1;
    d0 = n_deliv;
    repeat (12) step();
    check("bp_drained", n_deliv - d0, FD);
    check("bp_empty", instr_valid, 1'b0);

    // Redirect with words buffered.
    ena = 1'b1; instr_ready = 1'b0;
    repeat (4) step();
    check("pre_redir_valid", instr_valid, 1'b1);
    do_redirect(32'h40);
    check("redir_flush", instr_valid, 1'b0);
    instr_ready = 1'b1;
    wait_valid("redir_wait");
    check("redir_pc", instr_pc, 32'h40);
    check("redir_instr", instr, model_mem[16]);

    // Wrap at the top of memory.
    do_redirect(32'hFFC);
    wait_valid("wrap_wait");
    check("wrap_pc0", instr_pc, 32'hFFC);
    check("wrap_instr0", instr, model_mem[2**AW-1]);
    step();
    check("wrap_pc1", instr_pc, 32'h1000);
    check("wrap_instr1", instr, model_mem[0]);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      ena         = ($urandom_range(3) != 0);
      instr_ready = $urandom_range(1);
      if ($urandom_range(19) == 0) begin
`ifdef IFETCH_ALIGN_CHK_EN
        do_redirect($urandom & ~32'h3);
`else
        do_redirect($urandom);
`endif
      end else
        step();
    end

    // Reset while the FIFO is full.
    ena = 1'b1; instr_ready = 1'b0;
    repeat (8) step();
    check("full_valid", instr_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", instr_valid, 1'b0);
    check("async_rst_instr", instr, '0);
    check("async_rst_pc", instr_pc, '0);
    step(); step();
    instr_ready = 1'b1;
    #2 rst_n = 1'b1;
    wait_valid("restart_wait");
    check("restart_pc", instr_pc, RPC);
    check("restart_instr", instr, model_mem[RPC[AW+1:2]]);

`ifdef IFETCH_ALIGN_CHK_EN
    do_redirect(32'h42);
    check("align_fault_set", fault, 1'b1);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid) vcnt++;
      step();
    end
    check("align_no_valid", vcnt, 0);
    check("align_fault_sticky", fault, 1'b1);
    do_redirect(32'h44);
    check("align_fault_clr", fault, 1'b0);
    wait_valid("align_wait");
    check("align_pc", instr_pc, 32'h44);
    check("align_instr", instr, model_mem[17]);
`else
    do_redirect(32'h42);
    wait_valid("lowbits_wait");
    check("lowbits_pc", instr_pc, 32'h40);
    check("lowbits_instr", instr, model_mem[16]);
`endif

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
